// File: rtl/control_sequencer_if.sv
// Bundle between the micro-sequencer and the bus datapath: instruction/flags in, load/drive strobes out.
// Strobes are level signals valid for exactly one clock; there is no valid/ready pairing and no back-pressure.
interface control_sequencer_if;
  logic [7:0] ir;
  logic       carry_flag;
  logic       zero_flag;
  logic       pc_out;
  logic       pc_inc;
  logic       pc_load;
  logic       mar_in;
  logic       ram_out;
  logic       ram_in;
  logic       ir_in;
  logic       ir_out;
  logic       a_in;
  logic       a_out;
  logic       b_in;
  logic       sum_out;
  logic       alu_sub;
  logic       flags_in;
  logic       out_in;
  logic       halt;
  logic [2:0] step;

  modport master (
    input  ir, carry_flag, zero_flag,
    output pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, sum_out, alu_sub, flags_in, out_in, halt, step
  );

  modport slave (
    output ir, carry_flag, zero_flag,
    input  pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
           a_in, a_out, b_in, sum_out, alu_sub, flags_in, out_in, halt, step
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute micro-sequencer for the 8-bit bus CPU: a T0..T4 step counter plus a halted flag,
// with all bus strobes decoded combinationally from (step, ir, flags, halted).
module control_sequencer #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  control_sequencer_if.master bus
);
  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

  step_t      step_q, step_d;
  logic       halted_q, halted_d;
  logic [3:0] opcode;
  logic       illegal;

  assign opcode   = bus.ir[7:4];
  assign illegal  = (opcode >= 4'h9) && (opcode <= 4'hD);
  assign bus.halt = halted_q;
  assign bus.step = step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    bus.pc_out   = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.mar_in   = 1'b0;
    bus.ram_out  = 1'b0;
    bus.ram_in   = 1'b0;
    bus.ir_in    = 1'b0;
    bus.ir_out   = 1'b0;
    bus.a_in     = 1'b0;
    bus.a_out    = 1'b0;
    bus.b_in     = 1'b0;
    bus.sum_out  = 1'b0;
    bus.alu_sub  = 1'b0;
    bus.flags_in = 1'b0;
    bus.out_in   = 1'b0;
    step_d       = T0;
    halted_d     = halted_q;
    // rst is folded in here so the strobes drop the moment reset asserts, not at the next edge.
    if (!rst && !halted_q) begin
      case (step_q)
        T0: begin
          bus.pc_out = 1'b1;
          bus.mar_in = 1'b1;
          step_d     = T1;
        end
        T1: begin
          bus.ram_out = 1'b1;
          bus.ir_in   = 1'b1;
          bus.pc_inc  = 1'b1;
          step_d      = T2;
        end
        T2: begin
          case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4: begin
              bus.ir_out = 1'b1;
              bus.mar_in = 1'b1;
              step_d     = T3;
            end
            4'h5: begin
              bus.ir_out = 1'b1;
              bus.a_in   = 1'b1;
            end
            4'h6: begin
              bus.ir_out  = 1'b1;
              bus.pc_load = 1'b1;
            end
            4'h7: begin
              bus.ir_out  = bus.carry_flag;
              bus.pc_load = bus.carry_flag;
            end
            4'h8: begin
              bus.ir_out  = bus.zero_flag;
              bus.pc_load = bus.zero_flag;
            end
            4'hE: begin
              bus.a_out  = 1'b1;
              bus.out_in = 1'b1;
            end
            4'hF:    halted_d = 1'b1;
            default: halted_d = HALT_ON_ILLEGAL && illegal;
          endcase
        end
        T3: begin
          case (opcode)
            4'h1: begin
              bus.ram_out = 1'b1;
              bus.a_in    = 1'b1;
            end
            4'h2, 4'h3: begin
              bus.ram_out = 1'b1;
              bus.b_in    = 1'b1;
              step_d      = T4;
            end
            4'h4: begin
              bus.a_out  = 1'b1;
              bus.ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == 4'h2 || opcode == 4'h3) begin
            bus.sum_out  = 1'b1;
            bus.a_in     = 1'b1;
            bus.flags_in = 1'b1;
            bus.alu_sub  = (opcode == 4'h3);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded fetch/decode/execute controller for the 8-bit bus CPU.
- Sits upstream of every bus register (A, B, IR, MAR, OUT) and of the PC, RAM and ALU. It generates the per-cycle load/drive strobes that select which unit writes or reads the shared 8-bit data bus.
- Consumes the instruction byte held in IR and the ALU flags.

Parameters:
HALT_ON_ILLEGAL, 0, 1 = undefined opcodes enter HALT; 0 = undefined opcodes execute as NOP.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous reset, active-high
ir  input  8  current instruction; [7:4] opcode, [3:0] operand/address
carry_flag  input  1  registered ALU carry
zero_flag  input  1  registered ALU zero
pc_out  output  1  PC drives bus
pc_inc  output  1  PC increments at next edge
pc_load  output  1  PC loads bus[3:0]
mar_in  output  1  MAR loads bus[3:0]
ram_out  output  1  RAM[MAR] drives bus
ram_in  output  1  RAM[MAR] loads bus
ir_in  output  1  IR loads bus
ir_out  output  1  IR drives {4'h0, ir[3:0]} on bus
a_in  output  1  A loads bus
a_out  output  1  A drives bus
b_in  output  1  B loads bus
sum_out  output  1  ALU result drives bus
alu_sub  output  1  ALU subtracts (A-B) instead of adding
flags_in  output  1  flag register captures ALU carry/zero
out_in  output  1  output register loads bus
halt  output  1  CPU halted
step  output  3  current micro-step T0..T4 (debug)

Behaviour:
- State: 3-bit step counter plus 1-bit halted flag. On rst (async): step=0, halted=0, all strobes 0, halt=0.
- Strobes are a combinational decode of (step, ir, flags, halted). When halted=1, every strobe is 0 and halt=1.
- At most one bus driver (pc_out, ram_out, ir_out, a_out, sum_out) is active in any step. This is a required invariant.
- Fetch, common to all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_inc.
- Execute from T2. The last listed step returns to T0 at the next edge; otherwise step+1.
  - 0x0 NOP: T2 none, last=T2.
  - 0x1 LDA: T2 ir_out,mar_in; T3 ram_out,a_in; last=T3.
  - 0x2 ADD: T2 ir_out,mar_in; T3 ram_out,b_in; T4 sum_out,a_in,flags_in; last=T4.
  - 0x3 SUB: same as ADD with alu_sub=1 in T4.
  - 0x4 STA: T2 ir_out,mar_in; T3 a_out,ram_in; last=T3.
  - 0x5 LDI: T2 ir_out,a_in; last=T2.
  - 0x6 JMP: T2 ir_out,pc_load; last=T2.
  - 0x7 JC: T2 ir_out,pc_load only if carry_flag=1, else none; last=T2.
  - 0x8 JZ: as JC using zero_flag.
  - 0xE OUT: T2 a_out,out_in; last=T2.
  - 0xF HLT: in T2, halted<=1 at the edge, step<=0; T2 asserts no strobes.
  - 0x9–0xD: NOP, or HALT like 0xF when HALT_ON_ILLEGAL=1.
- Flags are sampled combinationally in T2. Flags written by flags_in at the T4 edge of a prior ADD/SUB are visible.
- ir is considered stable only from T2 onward. T0/T1 decode ignores ir.
- Step never exceeds 4. Any unreachable step value (5–7) goes to T0 on the next edge with no strobes.
- Halted persists until rst. rst asserted mid-instruction aborts immediately: strobes drop asynchronously and the next fetch starts at T0 after rst deasserts.

Test Plan:
1. Reset then release, ir=8'h00 -> step sequence 0,1,2,0; pc_out&mar_in at T0, ram_out&ir_in&pc_inc at T1, no strobes at T2.
2. ir=8'h2A (ADD 10) -> T2 ir_out,mar_in; T3 ram_out,b_in; T4 sum_out,a_in,flags_in, alu_sub=0; then step=0. Repeat with 8'h3A -> alu_sub=1 only in T4.
3. ir=8'h73 (JC 3) with carry_flag=0 -> no pc_load in T2; with carry_flag=1 -> ir_out&pc_load in T2. Same check for 8'h85 with zero_flag.
4. ir=8'hF0 -> after T2 edge halt=1, step=0, all strobes 0 for 20 cycles regardless of ir/flags; rst -> halt=0, fetch resumes.
5. ir=8'hB0 with HALT_ON_ILLEGAL=0 -> 3-step NOP; with HALT_ON_ILLEGAL=1 -> halt=1 after T2.
6. Assert rst during T3 of LDA (8'h14) -> all strobes 0 asynchronously, step=0. Across a random-opcode run, never more than one bus driver is active in any cycle.
